// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel-1 transmit types used by the RX bookkeeper and its bench.
package ccip_if_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef struct packed {
    logic [5:0]   rsvd6;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd2;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd1;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

endpackage

// File: rtl/ccip_rx_bookkeeper.sv
// Coalesces per-flow RX consumption events and writes each flow's RX head back to the CPU.
// Optional idle-timeout flush is enabled by defining CCIP_BK_TIMEOUT_EN.
module ccip_rx_bookkeeper
  import ccip_if_pkg::*;
#(
  parameter int unsigned NIC_ID             = 0,
  parameter int unsigned LMAX_NUM_OF_FLOWS  = 1,
  parameter int unsigned LMAX_RX_QUEUE_SIZE = 1,
  parameter int unsigned BK_TIMEOUT         = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  t_ccip_clAddr                  rx_bk_base_addr,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
  input  logic [LMAX_RX_QUEUE_SIZE-1:0] rx_queue_size,
  input  logic [2:0]                    l_bk_batch,
  input  logic                          start,
  input  logic                          ev_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  ev_flow_id,
  input  logic [LMAX_RX_QUEUE_SIZE-1:0] ev_queue_entry,
  input  logic                          sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx                sTx_c1,
  output logic                          bk_pending,
  output logic                          error
);

  localparam int unsigned LF       = LMAX_NUM_OF_FLOWS;
  localparam int unsigned QW       = LMAX_RX_QUEUE_SIZE;
  localparam int unsigned NumFlows = 1 << LF;

  localparam logic [1:0] BkIdle  = 2'd0;
  localparam logic [1:0] BkScan  = 2'd1;
  localparam logic [1:0] BkWrite = 2'd2;

  if (BK_TIMEOUT < 1 || BK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("ccip_rx_bookkeeper[%0d]: BK_TIMEOUT %0d out of range", NIC_ID, BK_TIMEOUT);
  end

  logic [QW:0]   pend_q [NumFlows];
  logic [QW:0]   pend_d [NumFlows];
  logic [QW-1:0] head_q [NumFlows];
  logic [QW-1:0] head_d [NumFlows];

  logic [1:0]    state_q, state_d;
  logic [LF-1:0] scan_ptr_q, scan_ptr_d, scan_next;
  logic [31:0]   seq_q;
  logic          bk_pending_q, bk_pending_d;
  logic          error_q, err_hit;
  logic          go_write, advance, flush_all, flush_cond;
  logic [QW:0]   pend_scan, pend_full;
  t_if_ccip_c1_Tx     tx_q;
  t_ccip_c1_ReqMemHdr hdr_d;
  t_ccip_clData       data_d;

  assign pend_full = {1'b0, rx_queue_size} + (QW+1)'(1);

  // Clear of the flow in BkWrite is applied before a same-cycle event so the event survives.
  always_comb begin
    for (int f = 0; f < NumFlows; f++) begin
      pend_d[f] = pend_q[f];
      head_d[f] = head_q[f];
    end
    err_hit = 1'b0;
    if (state_q == BkWrite) pend_d[scan_ptr_q] = '0;
    if (ev_valid) begin
      err_hit = (pend_d[ev_flow_id] == pend_full);
      head_d[ev_flow_id] = (ev_queue_entry == rx_queue_size) ? '0 : ev_queue_entry + QW'(1);
      if (pend_d[ev_flow_id] != {1'b1, {QW{1'b0}}}) pend_d[ev_flow_id] = pend_d[ev_flow_id] + (QW+1)'(1);
    end
    bk_pending_d = 1'b0;
    for (int f = 0; f < NumFlows; f++) bk_pending_d = bk_pending_d | (pend_d[f] != '0);
  end

  assign pend_scan  = pend_q[scan_ptr_q];
  assign flush_cond = (32'(pend_scan) >= (32'd1 << l_bk_batch)) || (flush_all && pend_scan != '0);
  assign scan_next  = (scan_ptr_q == number_of_flows) ? '0 : scan_ptr_q + LF'(1);

  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    go_write   = 1'b0;
    advance    = 1'b0;
    case (state_q)
      BkIdle: if (start) state_d = BkScan;
      BkScan: begin
        if (!start) begin
          state_d = BkIdle;
        end else if (flush_cond && !sRx_c1TxAlmFull) begin
          state_d  = BkWrite;
          go_write = 1'b1;
        end else begin
          scan_ptr_d = scan_next;
          advance    = 1'b1;
        end
      end
      BkWrite: begin
        scan_ptr_d = scan_next;
        advance    = 1'b1;
        state_d    = BkScan;
      end
      default: state_d = BkIdle;
    endcase
  end

  always_comb begin
    hdr_d          = '0;
    hdr_d.vc_sel   = eVC_VH0;
    hdr_d.sop      = 1'b1;
    hdr_d.cl_len   = eCL_LEN_1;
    hdr_d.req_type = eREQ_WRPUSH_I;
    hdr_d.address  = rx_bk_base_addr + t_ccip_clAddr'(scan_ptr_q);
    data_d         = '0;
    data_d[QW-1:0] = head_q[scan_ptr_q];
    data_d[63:32]  = seq_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < NumFlows; f++) begin
        pend_q[f] <= '0;
        head_q[f] <= '0;
      end
      state_q      <= BkIdle;
      scan_ptr_q   <= '0;
      seq_q        <= '0;
      bk_pending_q <= 1'b0;
      error_q      <= 1'b0;
      tx_q         <= '0;
    end else begin
      for (int f = 0; f < NumFlows; f++) begin
        pend_q[f] <= pend_d[f];
        head_q[f] <= head_d[f];
      end
      state_q      <= state_d;
      scan_ptr_q   <= scan_ptr_d;
      bk_pending_q <= bk_pending_d;
      if (err_hit) error_q <= 1'b1;
      if (state_q == BkWrite) seq_q <= seq_q + 32'd1;
      tx_q.valid <= go_write;
      if (go_write) begin
        tx_q.hdr  <= hdr_d;
        tx_q.data <= data_d;
      end
    end
  end

`ifdef CCIP_BK_TIMEOUT_EN
  logic [15:0] timer_q;
  logic        flush_all_q;
  logic [LF:0] wrap_cnt_q;

  // flush_all stays up until the scan pointer has visited every active flow once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q     <= '0;
      flush_all_q <= 1'b0;
      wrap_cnt_q  <= '0;
    end else begin
      if (flush_all_q && advance) begin
        if (wrap_cnt_q == {1'b0, number_of_flows}) begin
          flush_all_q <= 1'b0;
          wrap_cnt_q  <= '0;
        end else begin
          wrap_cnt_q <= wrap_cnt_q + (LF+1)'(1);
        end
      end
      if (state_q == BkWrite || !bk_pending_q) begin
        timer_q <= '0;
      end else if (timer_q == 16'(BK_TIMEOUT - 1)) begin
        timer_q     <= '0;
        flush_all_q <= 1'b1;
        wrap_cnt_q  <= '0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  assign flush_all = flush_all_q;
`else
  assign flush_all = 1'b0;
`endif

  assign sTx_c1     = tx_q;
  assign bk_pending = bk_pending_q;
  assign error      = error_q;

endmodule
